reg_display_mux: RTL and testbench

Parametrised seven-segment scan controller for the multi-register debug display. It succeeds the fixed two-register (R0/R1) display path in the top-level. It accepts NUM_CH 32-bit register taps from the core and shows one channel at a time as hex digits. The channel is chosen by a step input or by an auto-rotate timer, and the displayed word is snapshotted once per scan frame so it never tears mid-frame. It sits between the core's register taps and the board's `seg`/`an` pins.

---
 rtl/reg_display_mux.sv | 151 +++++++++++++++
 tb/tb_reg_display_mux.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_display_mux.sv
// reg_display_mux: seven-segment scan controller for the multi-register debug display.
// Shows one of NUM_CH 32-bit register taps as hex digits. The displayed word is
// snapshotted once per scan frame so a digit sweep never mixes two values.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-low reset
//   ch_data    - flattened taps, channel i at [32*i+31:32*i]
//   step       - level input; each rising edge advances the channel
//   auto_en    - auto-rotate the channel every ROTATE_DIV cycles
//   half_sel   - 4-digit builds: 0 shows nibbles 3..0, 1 shows nibbles 7..4
//   freeze     - hold the snapshot
//   seg        - active-low segments, seg[0]=a .. seg[6]=g (registered)
//   an         - active-low one-hot digit enables (registered)
//   ch_sel     - index of the current channel
//   frame_tick - one-cycle pulse in the last cycle of each scan frame
module reg_display_mux #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 16,
  parameter int unsigned ROTATE_DIV = 1024,
  localparam int unsigned ChW       = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [32*NUM_CH-1:0]    ch_data,
  input  logic                    step,
  input  logic                    auto_en,
  input  logic                    half_sel,
  input  logic                    freeze,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [ChW-1:0]          ch_sel,
  output logic                    frame_tick
);

  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam int unsigned DigW = $clog2(NUM_DIGITS);
  localparam int unsigned RotW = $clog2(ROTATE_DIV);

  logic [PreW-1:0]       presc_q, presc_d;
  logic [DigW-1:0]       digit_q, digit_d;
  logic [31:0]           snap_q, snap_d;
  logic [ChW-1:0]        ch_sel_q, ch_sel_d;
  logic [RotW-1:0]       rot_q, rot_d;
  logic                  step_q;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic        presc_wrap;
  logic        step_edge;
  logic        rot_tc;
  logic        advance;
  logic [31:0] ch_word;
  logic [2:0]  nib_idx;
  logic [3:0]  nib;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan timing
  assign presc_wrap = (presc_q == PreW'(SCAN_DIV - 1));
  assign frame_tick = presc_wrap && (digit_q == DigW'(NUM_DIGITS - 1));

  always_comb begin
    presc_d = presc_wrap ? '0 : presc_q + 1'b1;
    digit_d = digit_q;
    if (presc_wrap) begin
      digit_d = (digit_q == DigW'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end
  end

  // Channel selection: a step edge and a rotate terminal count in the same
  // cycle collapse into a single advance.
  assign step_edge = step & ~step_q;
  assign rot_tc    = auto_en & (rot_q == RotW'(ROTATE_DIV - 1));
  assign advance   = step_edge | rot_tc;

  always_comb begin
    ch_sel_d = ch_sel_q;
    if (advance) begin
      ch_sel_d = (ch_sel_q == ChW'(NUM_CH - 1)) ? '0 : ch_sel_q + 1'b1;
    end
    // Step edges restart the rotate interval so the next auto-advance is a full
    // ROTATE_DIV away from a manual one.
    rot_d = (!auto_en || advance) ? '0 : rot_q + 1'b1;
  end

  // Snapshot loads only at frame end, so a channel change never tears a frame
  assign ch_word = ch_data[32*ch_sel_q +: 32];
  assign snap_d  = (frame_tick && !freeze) ? ch_word : snap_q;

  // Digit content and output decode
  always_comb begin
    if (NUM_DIGITS == 8) begin
      nib_idx = 3'(digit_q);
    end else begin
      nib_idx = {half_sel, digit_q[1:0]};
    end
    nib   = snap_q[4*nib_idx +: 4];
    seg_d = hex_to_seg(nib);
    an_d  = ~(NUM_DIGITS'(1) << digit_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      digit_q  <= '0;
      snap_q   <= '0;
      ch_sel_q <= '0;
      rot_q    <= '0;
      step_q   <= 1'b0;
      seg_q    <= 7'h7F;
      an_q     <= '1;
    end else begin
      presc_q  <= presc_d;
      digit_q  <= digit_d;
      snap_q   <= snap_d;
      ch_sel_q <= ch_sel_d;
      rot_q    <= rot_d;
      step_q   <= step;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg    = seg_q;
  assign an     = an_q;
  assign ch_sel = ch_sel_q;

endmodule

// File: tb/tb_reg_display_mux.sv
module tb_reg_display_mux;

  localparam int NCH   = 4;
  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int RD    = 8;
  localparam int FRAME = ND * SD;

  logic             clk;
  logic             reset;
  logic [32*NCH-1:0] ch_data;
  logic             step;
  logic             auto_en;
  logic             half_sel;
  logic             freeze;
  logic [6:0]       seg;
  logic [ND-1:0]    an;
  logic [1:0]       ch_sel;
  logic             frame_tick;

  int errors = 0;
  int checks = 0;

  // Reference model: frame position, displayed word, channel, rotate interval
  int          m_cnt;
  int          m_ch;
  int          m_rot;
  logic [31:0] m_snap;
  logic        m_sprev;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic [1:0]  exp_ch;
  logic        exp_ft;

  reg_display_mux #(
    .NUM_CH     (NCH),
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .ROTATE_DIV (RD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_data    (ch_data),
    .step       (step),
    .auto_en    (auto_en),
    .half_sel   (half_sel),
    .freeze     (freeze),
    .seg        (seg),
    .an         (an),
    .ch_sel     (ch_sel),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] hex7(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_ch    = 0;
    m_rot   = 0;
    m_snap  = '0;
    m_sprev = 1'b0;
    exp_seg = 7'h7F;
    exp_an  = 4'hF;
    exp_ch  = 2'd0;
    exp_ft  = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs as they are now
  task automatic model_edge();
    int  dig;
    int  nib;
    bit  se;
    bit  tc;
    dig     = m_cnt / SD;
    nib     = dig + 4 * int'(half_sel);
    exp_seg = hex7(int'((m_snap >> (4 * nib)) & 32'hF));
    exp_an  = ~(4'b0001 << dig);
    if (m_cnt == FRAME - 1 && !freeze) m_snap = ch_data[32*m_ch +: 32];
    se = step && !m_sprev;
    tc = auto_en && (m_rot == RD - 1);
    if (se || tc) m_ch = (m_ch + 1) % NCH;
    if (!auto_en || se || tc) m_rot = 0;
    else m_rot = m_rot + 1;
    m_sprev = step;
    m_cnt   = (m_cnt + 1) % FRAME;
    exp_ch  = 2'(m_ch);
    exp_ft  = (m_cnt == FRAME - 1);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (an !== 4'hF) begin
      errors++;
      $display("FAIL reset_an got=%b exp=1111", an);
    end
    checks++;
    if (seg !== 7'h7F) begin
      errors++;
      $display("FAIL reset_seg got=%h exp=7f", seg);
    end
    checks++;
    if (ch_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_ch_sel got=%0d exp=0", ch_sel);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_tick got=%b exp=0", frame_tick);
    end
  endtask

  task automatic test_scan_snapshot();
    logic [6:0] want [4];
    want = '{7'h19, 7'h30, 7'h24, 7'h79};
    ch_data = {$urandom, $urandom, $urandom, 32'h0000_1234};
    release_reset();
    for (int i = 0; i < 48; i++) begin
      tick();
      checks++;
      if ({seg, an, ch_sel, frame_tick} !== {exp_seg, exp_an, exp_ch, exp_ft}) begin
        errors++;
        $display("FAIL scan cyc=%0d got seg=%h an=%b ch=%0d ft=%b exp seg=%h an=%b ch=%0d ft=%b",
                 i, seg, an, ch_sel, frame_tick, exp_seg, exp_an, exp_ch, exp_ft);
      end
      if (i == 0 || i == 4) begin
        checks++;
        if (seg !== 7'h40) begin
          errors++;
          $display("FAIL first_frame cyc=%0d got seg=%h exp=40", i, seg);
        end
      end
      if (i >= 16 && i < 32 && (i % 4) == 0) begin
        checks++;
        if (seg !== want[(i-16)/4]) begin
          errors++;
          $display("FAIL snapshot_digit cyc=%0d got seg=%h exp=%h", i, seg, want[(i-16)/4]);
        end
      end
    end
  endtask

  task automatic test_half_sel();
    logic [6:0] want [4];
    want = '{7'h21, 7'h46, 7'h03, 7'h08};
    ch_data[31:0] = 32'hABCD_1234;
    half_sel = 1'b1;
    for (int i = 0; i < 56; i++) begin
      tick();
      checks++;
      if ({seg, an, ch_sel, frame_tick} !== {exp_seg, exp_an, exp_ch, exp_ft}) begin
        errors++;
        $display("FAIL half_sel cyc=%0d got seg=%h an=%b ch=%0d ft=%b exp seg=%h an=%b ch=%0d ft=%b",
                 i, seg, an, ch_sel, frame_tick, exp_seg, exp_an, exp_ch, exp_ft);
      end
      if (i >= 40) begin
        for (int d = 0; d < 4; d++) begin
          if (an == ~(4'b0001 << d)) begin
            checks++;
            if (seg !== want[d]) begin
              errors++;
              $display("FAIL half_digit d=%0d got seg=%h exp=%h", d, seg, want[d]);
            end
          end
        end
      end
    end
    half_sel = 1'b0;
  endtask

  task automatic test_step();
    ch_data[63:32] = 32'h5A5A_C3E1;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    checks++;
    if (ch_sel !== 2'd1) begin
      errors++;
      $display("FAIL step_one got=%0d exp=1", ch_sel);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({seg, an, ch_sel, frame_tick} !== {exp_seg, exp_an, exp_ch, exp_ft}) begin
        errors++;
        $display("FAIL step cyc=%0d got seg=%h an=%b ch=%0d ft=%b exp seg=%h an=%b ch=%0d ft=%b",
                 i, seg, an, ch_sel, frame_tick, exp_seg, exp_an, exp_ch, exp_ft);
      end
    end
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      repeat (2) tick();
      step = 1'b0;
      repeat (3) tick();
      checks++;
      if (ch_sel !== exp_ch) begin
        errors++;
        $display("FAIL step_pulse p=%0d got=%0d exp=%0d", p, ch_sel, exp_ch);
      end
    end
    checks++;
    if (ch_sel !== 2'd0) begin
      errors++;
      $display("FAIL step_wrap got=%0d exp=0", ch_sel);
    end
  endtask

  task automatic test_auto_rotate();
    bit found;
    auto_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({seg, an, ch_sel, frame_tick} !== {exp_seg, exp_an, exp_ch, exp_ft}) begin
        errors++;
        $display("FAIL auto cyc=%0d got seg=%h an=%b ch=%0d ft=%b exp seg=%h an=%b ch=%0d ft=%b",
                 i, seg, an, ch_sel, frame_tick, exp_seg, exp_an, exp_ch, exp_ft);
      end
    end
    // Line a step edge up with the rotate terminal count
    found = 1'b0;
    for (int i = 0; i < 2 * RD && !found; i++) begin
      if (m_rot == RD - 1) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL auto_align got=timeout exp=terminal_count");
    end
    step = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      step = 1'b0;
      checks++;
      if ({seg, an, ch_sel, frame_tick} !== {exp_seg, exp_an, exp_ch, exp_ft}) begin
        errors++;
        $display("FAIL auto_coincide cyc=%0d got seg=%h an=%b ch=%0d ft=%b exp seg=%h an=%b ch=%0d ft=%b",
                 i, seg, an, ch_sel, frame_tick, exp_seg, exp_an, exp_ch, exp_ft);
      end
    end
    auto_en = 1'b0;
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    ch_data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3 * FRAME + 20; i++) begin
      if (i == 3 * FRAME) freeze = 1'b0;
      tick();
      checks++;
      if ({seg, an, ch_sel, frame_tick} !== {exp_seg, exp_an, exp_ch, exp_ft}) begin
        errors++;
        $display("FAIL freeze cyc=%0d got seg=%h an=%b ch=%0d ft=%b exp seg=%h an=%b ch=%0d ft=%b",
                 i, seg, an, ch_sel, frame_tick, exp_seg, exp_an, exp_ch, exp_ft);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 30) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 40) == 0) half_sel = ~half_sel;
      if ($urandom_range(0, 25) == 0) freeze = ~freeze;
      if ($urandom_range(0, 10) == 0) ch_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checks++;
      if ({seg, an, ch_sel, frame_tick} !== {exp_seg, exp_an, exp_ch, exp_ft}) begin
        errors++;
        $display("FAIL random cyc=%0d got seg=%h an=%b ch=%0d ft=%b exp seg=%h an=%b ch=%0d ft=%b",
                 i, seg, an, ch_sel, frame_tick, exp_seg, exp_an, exp_ch, exp_ft);
      end
    end
    step     = 1'b0;
    auto_en  = 1'b0;
    freeze   = 1'b0;
    half_sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    ch_data[31:0] = 32'h89AB_CDEF;
    repeat (FRAME + 7) tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({an, seg} !== {4'hF, 7'h7F}) begin
      errors++;
      $display("FAIL reset_mid got an=%b seg=%h exp an=1111 seg=7f", an, seg);
    end
    checks++;
    if ({ch_sel, frame_tick} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_ctrl got ch=%0d ft=%b exp ch=0 ft=0", ch_sel, frame_tick);
    end
    @(posedge clk);
    #1;
    release_reset();
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if ({seg, an, ch_sel, frame_tick} !== {exp_seg, exp_an, exp_ch, exp_ft}) begin
        errors++;
        $display("FAIL after_reset cyc=%0d got seg=%h an=%b ch=%0d ft=%b exp seg=%h an=%b ch=%0d ft=%b",
                 i, seg, an, ch_sel, frame_tick, exp_seg, exp_an, exp_ch, exp_ft);
      end
    end
  endtask

  initial begin
    ch_data  = '0;
    step     = 1'b0;
    auto_en  = 1'b0;
    half_sel = 1'b0;
    freeze   = 1'b0;
    model_reset();
    test_reset();
    test_scan_snapshot();
    test_half_sel();
    test_step();
    test_auto_rotate();
    test_freeze();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
